uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
// Shares one UART transmit line between NUM_REQ byte producers, e.g. FFT result stream and status/debug.
// - Round-robin arbitration, with optional burst lock so a multi-byte packet is sent contiguously.
// - Sequences its own baud timing: divider cleared at each frame start, so every bit lasts exactly DIV cycles.
// - Sits between the FFT/control logic and the FPGA tx pin.
// PARAMETERS
// BAUD_RATE   19200     line bit rate
// CLOCK_FREQ  12000000  clk frequency in Hz
// NUM_REQ     2         number of requesters (>=2)
// MAX_BURST   4         max bytes one requester sends per grant (>=1)
// (derived) DIV = CLOCK_FREQ/BAUD_RATE, integer truncation; DIV>=2 required
// PORTS
// clk        in   1            system clock, all logic on posedge
// rst_n      in   1            asynchronous active-low reset
// req_valid  in   NUM_REQ      requester i has a byte on req_data[8i+7:8i]
// req_data   in   8*NUM_REQ    byte per requester
// req_last   in   NUM_REQ      byte is final byte of packet (ends burst lock)
// req_ready  out  NUM_REQ      combinational; byte i accepted when valid&ready
// tx         out  1            serial line, idle high, registered
// busy       out  1            frame in progress (state != IDLE), registered
// grant_id   out  clog2(NUM_REQ)  index of current/last owner, registered
// BEHAVIOUR
// Reset (async, rst_n=0): tx=1, busy=0, grant_id=0, state=IDLE, lock=0, burst_cnt=0, rr_ptr=0; req_ready all 0.
// - Reset mid-frame drops the byte; tx returns high immediately.
// States: IDLE -> START -> DATA(8 bits) -> STOP -> IDLE. Bit counter 0..DIV-1 per bit, bit index 0..7.
// IDLE arbitration, same cycle, combinational:
// - lock=1 and req_valid[grant_id]=1: owner wins.
// - else: first valid index at or after rr_ptr (wrapping) wins; lock cleared.
// - No valid: all ready=0, stay IDLE.
// - Exactly one req_ready bit high, only in IDLE with a winner; never high outside IDLE.
// Accept edge (IDLE, valid&ready):
// - shift_reg<=data, grant_id<=winner, rr_ptr<=winner+1 mod NUM_REQ.
// - burst_cnt<=(continuing lock ? burst_cnt+1 : 1).
// - lock<=(!req_last[winner] && new burst_cnt<MAX_BURST).
// - state<=START; divider<=0.
// Framing: tx=0 for DIV cycles (START), then data LSB first, DIV cycles each, then tx=1 for DIV cycles (STOP).
// - At end of STOP -> IDLE.
// Timing:
// - Accept at cycle T: tx low from T+1; busy=1 T+1..T+10*DIV; IDLE again at T+1+10*DIV.
// - Back-to-back throughput: 10*DIV+1 cycles/byte.
// Lock release:
// - owner drops valid in an IDLE cycle -> lock cleared, normal RR same cycle, no stall cycle.
// - MAX_BURST reached, or req_last seen -> lock=0, next arbitration starts at owner+1.
// Inputs ignored outside IDLE; requester must hold data stable only while valid&&!ready.
// MAX_BURST=1: pure round robin per byte.
// TESTING (CLOCK_FREQ=40, BAUD_RATE=10 -> DIV=4, NUM_REQ=2 unless stated)
// 1 req0 single 0xA5 last=1 -> one ready[0] pulse; tx 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy 40 cycles; IDLE 1 cycle.
// 2 both valid continuously, last=1 each byte -> grant_id 0,1,0,1,...; each frame 41 cycles apart.
// 3 MAX_BURST=4, req0 4-byte packet (last on 4th), req1 valid -> req0 bytes 1-4 back-to-back, then req1.
// 4 MAX_BURST=4, req0 6-byte packet, last on 6th, req1 valid -> sequence 0,0,0,0,1,0,0 (req0 resumes after req1).
// 5 rst_n low during DATA bit 3 -> tx=1 and busy=0 immediately; after release, req0 wins with both valid.
// 6 req0 locked mid-packet, drops valid at IDLE while req1 valid -> req1 granted same cycle, lock=0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART tx line among NUM_REQ byte producers using
// round-robin arbitration with an optional burst lock that keeps a packet contiguous.
module uart_tx_scheduler #(
    parameter int BAUD_RATE  = 19200,
    parameter int CLOCK_FREQ = 12000000,
    parameter int NUM_REQ    = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);
    localparam int DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int GW  = $clog2(NUM_REQ);
    localparam int DW  = $clog2(DIV);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] win, cand;
    logic [BW-1:0] burst_q, burst_d;
    logic          lock_q, lock_d;
    logic          tx_q, tx_d;
    logic          busy_q;
    logic          cont, found, bit_end;
    int            idx;

    // A locked owner that is still valid wins outright; otherwise scan from rr_q with wrap.
    always_comb begin
        cont  = lock_q && req_valid_i[grant_q];
        found = cont;
        win   = grant_q;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx  = int'(rr_q) + i;
            idx  = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            cand = GW'(idx);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        lock_d      = lock_q;
        burst_d     = burst_q;
        req_ready_o = '0;
        bit_end     = (div_q == DW'(DIV - 1));
        case (state_q)
            IDLE: begin
                div_d  = '0;
                lock_d = 1'b0;
                if (found && rst_n) begin
                    req_ready_o[win] = 1'b1;
                    shift_d          = req_data_i[8*int'(win) +: 8];
                    grant_d          = win;
                    rr_d             = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                    burst_d          = cont ? burst_q + 1'b1 : BW'(1);
                    lock_d           = !req_last_i[win] && (int'(burst_d) < MAX_BURST);
                    state_d          = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? STOP : DATA;
                end
            end
            default: begin
                if (bit_end) begin
                    div_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
        // tx is registered from next-state values so the line moves on the same edge as the FSM.
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            lock_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            lock_q  <= lock_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenarios with producer queues, a UART line decoder
// and an expected-frame scoreboard (DIV=4, NUM_REQ=2, MAX_BURST=4).
module tb_uart_tx_scheduler;
    typedef struct {
        logic [7:0] d;
        logic       l;
    } by_t;
    typedef struct {
        int         id;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid_i = '0;
    logic [15:0] req_data_i = '0;
    logic [1:0]  req_last_i = '0;
    logic [1:0]  req_ready_o;
    logic        tx_o;
    logic        busy_o;
    logic [0:0]  grant_id_o;

    by_t  q0[$];
    by_t  q1[$];
    exp_t eq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_cnt = 0;
    int   mon_act = 0;
    int   mon_cnt = 0;
    int   mon_start = 0;
    int   prev_start = 0;
    int   mon_gid = 0;
    logic [7:0] mon_byte = '0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .BAUD_RATE(10), .CLOCK_FREQ(40), .NUM_REQ(2), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_o(tx_o),
        .busy_o(busy_o), .grant_id_o(grant_id_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put0(input logic [7:0] d, input logic l);
        q0.push_back('{d, l});
    endtask

    task automatic put1(input logic [7:0] d, input logic l);
        q1.push_back('{d, l});
    endtask

    task automatic expect_frame(input int id, input logic [7:0] d, input int gap);
        eq.push_back('{id, d, gap});
    endtask

    task automatic drive();
        req_valid_i = {q1.size() != 0, q0.size() != 0};
        req_data_i  = {(q1.size() != 0) ? q1[0].d : 8'h00, (q0.size() != 0) ? q0[0].d : 8'h00};
        req_last_i  = {(q1.size() != 0) ? q1[0].l : 1'b0, (q0.size() != 0) ? q0[0].l : 1'b0};
    endtask

    // One clock: decode the line at the negedge, drive producers, then check and pop accepted bytes.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (mon_act == 0 && tx_o === 1'b0) begin
            mon_act   = 1;
            mon_cnt   = 0;
            mon_start = cyc;
            mon_gid   = int'(grant_id_o);
            mon_byte  = '0;
        end
        if (mon_act == 0) chk("idle_busy", 32'(busy_o), 0);
        else begin
            chk("frame_busy", 32'(busy_o), 1);
            if (mon_cnt == 2) chk("start_bit", 32'(tx_o), 0);
            if (mon_cnt >= 6 && mon_cnt <= 34 && mon_cnt % 4 == 2) mon_byte = {tx_o, mon_byte[7:1]};
            if (mon_cnt == 38) chk("stop_bit", 32'(tx_o), 1);
            if (mon_cnt == 39) begin
                mon_act = 0;
                if (eq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_frame: observed byte %0h expected none", mon_byte);
                end else begin
                    e = eq.pop_front();
                    chk("frame_id", 32'(mon_gid), 32'(e.id));
                    chk("frame_data", 32'(mon_byte), 32'(e.data));
                    if (e.gap != 0) chk("frame_gap", 32'(mon_start - prev_start), 32'(e.gap));
                end
                prev_start = mon_start;
            end
            mon_cnt++;
        end
        drive();
        #1;
        if (req_ready_o != 2'b00) begin
            rdy_cnt++;
            chk("ready_onehot", 32'($onehot(req_ready_o)), 1);
            chk("ready_valid", 32'(req_ready_o & ~req_valid_i), 0);
            chk("ready_idle", 32'(busy_o), 0);
        end
        if (req_valid_i[0] && req_ready_o[0]) void'(q0.pop_front());
        if (req_valid_i[1] && req_ready_o[1]) void'(q1.pop_front());
    endtask

    task automatic drain();
        int n = 0;
        while ((eq.size() != 0 || mon_act != 0) && n < 800) begin
            step();
            n++;
        end
        chk("drain_left", 32'(eq.size()), 0);
        repeat (3) step();
    endtask

    initial begin
        int n;
        req_valid_i = 2'b11;
        req_data_i  = 16'h5A5A;
        #12;
        chk("rst_tx", 32'(tx_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_grant", 32'(grant_id_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        req_valid_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // single byte from req0: A5 serialises as 0,1,0,1,0,0,1,0,1,1
        rdy_cnt = 0;
        put0(8'hA5, 1'b1);
        expect_frame(0, 8'hA5, 0);
        drain();
        chk("t1_ready_pulses", 32'(rdy_cnt), 1);

        // both continuously valid, rr pointer at 1 after req0's byte
        for (int i = 0; i < 3; i++) begin
            put0(8'h10 + 8'(i), 1'b1);
            put1(8'h20 + 8'(i), 1'b1);
            expect_frame(1, 8'h20 + 8'(i), (i == 0) ? 0 : 41);
            expect_frame(0, 8'h10 + 8'(i), 41);
        end
        drain();

        // 4-byte packet from req0 stays contiguous although req1 joins after the first byte
        for (int i = 0; i < 4; i++) begin
            put0(8'h30 + 8'(i), i == 3);
            expect_frame(0, 8'h30 + 8'(i), (i == 0) ? 0 : 41);
        end
        expect_frame(1, 8'h40, 41);
        n = 0;
        while (q0.size() != 3 && n < 100) begin
            step();
            n++;
        end
        chk("t3_first_accept", 32'(q0.size()), 3);
        put1(8'h40, 1'b1);
        drain();

        // 6-byte packet hits MAX_BURST, req1 slips in, req0 resumes
        for (int i = 0; i < 6; i++) put0(8'h50 + 8'(i), i == 5);
        put1(8'h60, 1'b1);
        for (int i = 0; i < 4; i++) expect_frame(0, 8'h50 + 8'(i), (i == 0) ? 0 : 41);
        expect_frame(1, 8'h60, 41);
        expect_frame(0, 8'h54, 41);
        expect_frame(0, 8'h55, 41);
        drain();

        // locked owner drops valid at IDLE: req1 wins in that same cycle
        put0(8'h70, 1'b0);
        expect_frame(0, 8'h70, 0);
        n = 0;
        while (q0.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("t6_owner_accept", 32'(q0.size()), 0);
        put1(8'h80, 1'b1);
        expect_frame(1, 8'h80, 41);
        drain();

        // reset during DATA bit 3 drops the byte and restores rr pointer to 0
        put0(8'h3C, 1'b1);
        n = 0;
        while (!(mon_act != 0 && mon_cnt == 17) && n < 100) begin
            step();
            n++;
        end
        chk("t5_reached_bit3", 32'(mon_cnt), 17);
        @(negedge clk);
        rst_n = 1'b0;
        put0(8'h11, 1'b1);
        put1(8'h22, 1'b1);
        drive();
        #1;
        chk("t5_rst_tx", 32'(tx_o), 1);
        chk("t5_rst_busy", 32'(busy_o), 0);
        chk("t5_rst_grant", 32'(grant_id_o), 0);
        chk("t5_rst_ready", 32'(req_ready_o), 0);
        mon_act = 0;
        repeat (3) step();
        rst_n = 1'b1;
        expect_frame(0, 8'h11, 0);
        expect_frame(1, 8'h22, 41);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
